reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_if.sv | 31 +++
 rtl/reg_op_unit.sv | 54 +++++
 rtl/reg_bank.sv | 72 +++++++
 tb/tb_reg_bank.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: operation codes and default geometry.
package reg_bank_pkg;

  parameter int unsigned DefWidth = 8;
  parameter int unsigned DefDepth = 4;

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpInc = 3'b001,
    OpDec = 3'b010,
    OpShl = 3'b011,
    OpShr = 3'b100,
    OpRol = 3'b101,
    OpRor = 3'b110,
    OpClr = 3'b111
  } op_e;

endpackage

// File: rtl/reg_bank_if.sv
// Control, select and status signals of the register bank. The shared data bus
// itself is a plain inout port on reg_bank so tristate resolution stays on a net.
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
);
  localparam int unsigned SELW = $clog2(DEPTH);

  logic [SELW-1:0]  wr_sel;
  logic [SELW-1:0]  rd_sel;
  logic             bus_in;
  logic             bus_out;
  logic             op_en;
  op_e              op;
  logic [SELW-1:0]  cpu_sel;
  logic [WIDTH-1:0] cpu_data;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output wr_sel, rd_sel, bus_in, bus_out, op_en, op, cpu_sel,
    input  cpu_data, flag_z, flag_c
  );

  modport slave (
    input  wr_sel, rd_sel, bus_in, bus_out, op_en, op, cpu_sel,
    output cpu_data, flag_z, flag_c
  );
endinterface

// File: rtl/reg_op_unit.sv
// Combinational ALU for single-register operations: result and carry/shift-out.
module reg_op_unit
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] value_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  // Decode the op into a result and the bit that falls off (or wraps).
  always_comb begin
    result_o = value_i;
    carry_o  = 1'b0;
    unique case (op_i)
      OpNop: begin
        result_o = value_i;
        carry_o  = 1'b0;
      end
      OpInc: {carry_o, result_o} = {1'b0, value_i} + (WIDTH + 1)'(1);
      OpDec: begin
        result_o = value_i - WIDTH'(1);
        carry_o  = (value_i == '0);
      end
      OpShl: begin
        result_o = {value_i[WIDTH-2:0], 1'b0};
        carry_o  = value_i[WIDTH-1];
      end
      OpShr: begin
        result_o = {1'b0, value_i[WIDTH-1:1]};
        carry_o  = value_i[0];
      end
      OpRol: begin
        result_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
        carry_o  = value_i[WIDTH-1];
      end
      OpRor: begin
        result_o = {value_i[0], value_i[WIDTH-1:1]};
        carry_o  = value_i[0];
      end
      OpClr: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
      default: begin
        result_o = value_i;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank on a shared tristate bus with a direct CPU tap and Z/C flags.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire [WIDTH-1:0]  bus,
  reg_bank_if.slave        rb
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;

  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] op_result;
  logic             op_carry;

  assign rd_val = regs_q[rb.rd_sel];
  assign bus    = rb.bus_out ? rd_val : {WIDTH{1'bz}};

  // On a move we drive the bus ourselves, so take the value straight from the
  // register file instead of reading it back through the tristate net.
  assign load_val = rb.bus_out ? rd_val : bus;

  assign rb.cpu_data = regs_q[rb.cpu_sel];
  assign rb.flag_z   = flag_z_q;
  assign rb.flag_c   = flag_c_q;

  reg_op_unit #(
    .WIDTH (WIDTH)
  ) u_op_unit (
    .value_i  (regs_q[rb.wr_sel]),
    .op_i     (rb.op),
    .result_o (op_result),
    .carry_o  (op_carry)
  );

  // Next state: a load beats an op; only the wr_sel register may change.
  always_comb begin
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (rb.bus_in) begin
      regs_d[rb.wr_sel] = load_val;
      flag_z_d          = (load_val == '0);
    end else if (rb.op_en && (rb.op != OpNop)) begin
      regs_d[rb.wr_sel] = op_result;
      flag_z_d          = (op_result == '0);
      flag_c_d          = op_carry;
    end
  end

  // Storage and flags, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '{default: '0};
      flag_z_q <= 1'b1;
      flag_c_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: an 8-bit x4 instance and a 16-bit x8 instance.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic        tb_a_en;
  logic [7:0]  tb_a_val;
  logic        tb_b_en;
  logic [15:0] tb_b_val;
  wire  [7:0]  bus_a;
  wire  [15:0] bus_b;

  assign bus_a = tb_a_en ? tb_a_val : 8'bz;
  assign bus_b = tb_b_en ? tb_b_val : 16'bz;

  reg_bank_if #(.WIDTH(8),  .DEPTH(4)) rb_a ();
  reg_bank_if #(.WIDTH(16), .DEPTH(8)) rb_b ();

  reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a),
    .rb    (rb_a.slave)
  );

  reg_bank #(.WIDTH(16), .DEPTH(8)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b),
    .rb    (rb_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    tb_a_en = 1'b0; rb_a.bus_in = 1'b0; rb_a.bus_out = 1'b0; rb_a.op_en = 1'b0;
    rb_a.op = OpNop;
  endtask

  task automatic idle_b();
    tb_b_en = 1'b0; rb_b.bus_in = 1'b0; rb_b.bus_out = 1'b0; rb_b.op_en = 1'b0;
    rb_b.op = OpNop;
  endtask

  task automatic load_a(input logic [1:0] sel, input logic [7:0] val);
    tb_a_en = 1'b1; tb_a_val = val; rb_a.bus_in = 1'b1; rb_a.wr_sel = sel;
    tick();
    idle_a();
  endtask

  task automatic op_a(input logic [1:0] sel, input op_e op);
    rb_a.op_en = 1'b1; rb_a.op = op; rb_a.wr_sel = sel;
    tick();
    idle_a();
  endtask

  task automatic peek_a(input logic [1:0] sel, output logic [7:0] v);
    rb_a.cpu_sel = sel;
    #1;
    v = rb_a.cpu_data;
  endtask

  task automatic peek_b(input logic [2:0] sel, output logic [15:0] v);
    rb_b.cpu_sel = sel;
    #1;
    v = rb_b.cpu_data;
  endtask

  logic [7:0]  va;
  logic [15:0] vb;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tb_a_val = '0; tb_b_val = '0;
    rb_a.wr_sel = '0; rb_a.rd_sel = '0; rb_a.cpu_sel = '0;
    rb_b.wr_sel = '0; rb_b.rd_sel = '0; rb_b.cpu_sel = '0;
    idle_a();
    idle_b();
    #12 rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      peek_a(2'(i), va);
      check("rst_reg", {8'h0, va}, 16'h0000);
    end
    check("rst_z", {15'h0, rb_a.flag_z}, 16'h0001);
    check("rst_c", {15'h0, rb_a.flag_c}, 16'h0000);

    // Load and move
    load_a(2'd1, 8'hA5);
    peek_a(2'd1, va);
    check("load_r1", {8'h0, va}, 16'h00A5);
    check("load_z", {15'h0, rb_a.flag_z}, 16'h0000);
    rb_a.bus_out = 1'b1; rb_a.rd_sel = 2'd1;
    #1;
    check("bus_read", {8'h0, bus_a}, 16'h00A5);
    rb_a.bus_in = 1'b1; rb_a.wr_sel = 2'd2;
    tick();
    idle_a();
    peek_a(2'd2, va);
    check("move_r2", {8'h0, va}, 16'h00A5);
    peek_a(2'd1, va);
    check("move_r1", {8'h0, va}, 16'h00A5);
    check("move_z", {15'h0, rb_a.flag_z}, 16'h0000);

    // Bus released when bus_out=0: an external driver wins cleanly
    tb_a_en = 1'b1; tb_a_val = 8'h3C;
    #1;
    check("tristate_a", {8'h0, bus_a}, 16'h003C);
    tb_a_en = 1'b0;

    // Wrap
    load_a(2'd0, 8'hFF);
    op_a(2'd0, OpInc);
    peek_a(2'd0, va);
    check("inc_wrap", {8'h0, va}, 16'h0000);
    check("inc_z", {15'h0, rb_a.flag_z}, 16'h0001);
    check("inc_c", {15'h0, rb_a.flag_c}, 16'h0001);
    op_a(2'd0, OpDec);
    peek_a(2'd0, va);
    check("dec_wrap", {8'h0, va}, 16'h00FF);
    check("dec_c", {15'h0, rb_a.flag_c}, 16'h0001);
    check("dec_z", {15'h0, rb_a.flag_z}, 16'h0000);

    // Load beats op; carry untouched by a load
    tb_a_en = 1'b1; tb_a_val = 8'h10; rb_a.bus_in = 1'b1;
    rb_a.op_en = 1'b1; rb_a.op = OpInc; rb_a.wr_sel = 2'd0;
    tick();
    idle_a();
    peek_a(2'd0, va);
    check("conflict_r0", {8'h0, va}, 16'h0010);
    check("conflict_c", {15'h0, rb_a.flag_c}, 16'h0001);
    check("conflict_z", {15'h0, rb_a.flag_z}, 16'h0000);

    // NOP holds value and flags
    op_a(2'd0, OpNop);
    peek_a(2'd0, va);
    check("nop_r0", {8'h0, va}, 16'h0010);
    check("nop_c", {15'h0, rb_a.flag_c}, 16'h0001);

    // Shifts and rotates
    load_a(2'd3, 8'h81);
    op_a(2'd3, OpShl);
    peek_a(2'd3, va);
    check("shl", {8'h0, va}, 16'h0002);
    check("shl_c", {15'h0, rb_a.flag_c}, 16'h0001);
    op_a(2'd3, OpShr);
    peek_a(2'd3, va);
    check("shr", {8'h0, va}, 16'h0001);
    check("shr_c", {15'h0, rb_a.flag_c}, 16'h0000);
    load_a(2'd3, 8'h81);
    op_a(2'd3, OpRor);
    peek_a(2'd3, va);
    check("ror", {8'h0, va}, 16'h00C0);
    check("ror_c", {15'h0, rb_a.flag_c}, 16'h0001);
    op_a(2'd3, OpRol);
    peek_a(2'd3, va);
    check("rol", {8'h0, va}, 16'h0081);
    check("rol_c", {15'h0, rb_a.flag_c}, 16'h0001);
    op_a(2'd3, OpClr);
    peek_a(2'd3, va);
    check("clr", {8'h0, va}, 16'h0000);
    check("clr_z", {15'h0, rb_a.flag_z}, 16'h0001);
    check("clr_c", {15'h0, rb_a.flag_c}, 16'h0000);
    peek_a(2'd1, va);
    check("hold_r1", {8'h0, va}, 16'h00A5);
    peek_a(2'd0, va);
    check("hold_r0", {8'h0, va}, 16'h0010);

    // 16-bit, 8-deep instance
    tb_b_en = 1'b1; tb_b_val = 16'hFFFF; rb_b.bus_in = 1'b1; rb_b.wr_sel = 3'd5;
    tick();
    idle_b();
    rb_b.op_en = 1'b1; rb_b.op = OpInc; rb_b.wr_sel = 3'd5;
    tick();
    idle_b();
    peek_b(3'd5, vb);
    check("b_inc_wrap", vb, 16'h0000);
    check("b_inc_z", {15'h0, rb_b.flag_z}, 16'h0001);
    check("b_inc_c", {15'h0, rb_b.flag_c}, 16'h0001);
    rb_b.op_en = 1'b1; rb_b.op = OpDec; rb_b.wr_sel = 3'd5;
    tick();
    idle_b();
    peek_b(3'd5, vb);
    check("b_dec_wrap", vb, 16'hFFFF);
    check("b_dec_c", {15'h0, rb_b.flag_c}, 16'h0001);
    check("b_dec_z", {15'h0, rb_b.flag_z}, 16'h0000);
    rb_b.bus_out = 1'b1; rb_b.rd_sel = 3'd5;
    #1;
    check("b_bus_read", bus_b, 16'hFFFF);
    rb_b.bus_out = 1'b0;
    tb_b_en = 1'b1; tb_b_val = 16'h1234;
    #1;
    check("b_tristate", bus_b, 16'h1234);
    tb_b_en = 1'b0;

    // Asynchronous reset in the middle of an INC
    rb_a.op_en = 1'b1; rb_a.op = OpInc; rb_a.wr_sel = 2'd0;
    rb_a.bus_out = 1'b1; rb_a.rd_sel = 2'd1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      peek_a(2'(i), va);
      check("arst_reg", {8'h0, va}, 16'h0000);
    end
    check("arst_z", {15'h0, rb_a.flag_z}, 16'h0001);
    check("arst_c", {15'h0, rb_a.flag_c}, 16'h0000);
    check("arst_bus", {8'h0, bus_a}, 16'h0000);
    peek_b(3'd5, vb);
    check("arst_b", vb, 16'h0000);
    tick();
    peek_a(2'd0, va);
    check("arst_hold", {8'h0, va}, 16'h0000);
    rst_n = 1'b1;
    tick();
    idle_a();
    peek_a(2'd0, va);
    check("post_rst_inc", {8'h0, va}, 16'h0001);
    check("post_rst_z", {15'h0, rb_a.flag_z}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
